// File: rtl/adc_frame_pkg.sv
// Shared definitions for the ADC frame transmitter: FSM encodings, frame header
// and the frame-length helper used to size byte indexing.
package adc_frame_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SCAN    = 2'd1,
      ST_SEND    = 2'd2,
      ST_WAIT_TX = 2'd3
   } frame_state_t;

   localparam logic [7:0] FRAME_HDR    = 8'hA5;
   localparam logic [9:0] TIMEOUT_FILL = 10'h3FF;

   // Header + two bytes per channel + checksum.
   function automatic int unsigned frame_len(input int unsigned num_ch);
      return 2 * num_ch + 2;
   endfunction

   function automatic logic [7:0] slot_hi_byte(input logic [3:0] ch, input logic [9:0] s);
      return {ch, 2'b00, s[9:8]};
   endfunction

endpackage

// File: rtl/adc_frame_tx.sv
// Scans NUM_CHANNELS ADC channels into a slot array, then streams a framed,
// checksummed byte sequence to a serial transmitter one handshake at a time.
module adc_frame_tx
   import adc_frame_pkg::*;
#(
   parameter int NUM_CHANNELS   = 8,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   output logic [3:0] channel,
   input  logic       new_sample,
   input  logic [9:0] sample,
   input  logic [3:0] sample_channel,
   output logic [7:0] tx_data,
   output logic       new_tx_data,
   input  logic       tx_busy,
   output logic       busy,
   output logic       frame_done,
   output logic       timeout_err
);

   localparam int KW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int BW = 6;

   localparam logic [3:0]    LAST_K = 4'(NUM_CHANNELS - 1);
   localparam logic [BW-1:0] LAST_B = BW'(frame_len(NUM_CHANNELS) - 1);
   localparam logic [TW-1:0] TMAX   = TW'(TIMEOUT_CYCLES - 1);

   frame_state_t  state;
   logic [1:0]    rst_sync;
   logic          run;
   logic [3:0]    k;
   logic [TW-1:0] tcnt;
   logic [9:0]    slots [NUM_CHANNELS];
   logic [BW-1:0] bidx;
   logic [7:0]    csum;
   logic          wait_first;

   logic          hit;
   logic          expired;
   logic [4:0]    boff;
   logic [3:0]    bch;
   logic [7:0]    cur_byte;

   // Reset release is retimed through two flops so the FSM never moves on the
   // same edges where rst_n deasserts asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end

   assign run     = rst_sync[1];
   assign hit     = new_sample && (sample_channel == k);
   assign expired = (tcnt == TMAX);

   // Byte bidx of the frame: 0 is the header, odd/even pairs map to slot
   // low/high bytes, and the final index is the running checksum.
   always_comb begin
      boff     = 5'(bidx - 1'b1);
      bch      = boff[4:1];
      cur_byte = FRAME_HDR;
      if (bidx == LAST_B) begin
         cur_byte = csum;
      end else if (bidx != '0) begin
         if (boff[0]) cur_byte = slot_hi_byte(bch, slots[bch[KW-1:0]]);
         else         cur_byte = slots[bch[KW-1:0]][7:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         k           <= '0;
         tcnt        <= '0;
         bidx        <= '0;
         csum        <= '0;
         wait_first  <= 1'b0;
         channel     <= '0;
         tx_data     <= '0;
         new_tx_data <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         timeout_err <= 1'b0;
         for (int i = 0; i < NUM_CHANNELS; i++) slots[i] <= '0;
      end else if (run) begin
         new_tx_data <= 1'b0;
         frame_done  <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (enable) begin
                  k       <= '0;
                  channel <= '0;
                  tcnt    <= '0;
                  busy    <= 1'b1;
                  state   <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               // A matching strobe wins over an expiring counter on the same cycle.
               if (hit || expired) begin
                  slots[k[KW-1:0]] <= hit ? sample : TIMEOUT_FILL;
                  timeout_err      <= !hit;
                  tcnt             <= '0;
                  if (k != LAST_K) begin
                     k       <= k + 4'd1;
                     channel <= k + 4'd1;
                  end else begin
                     bidx  <= '0;
                     csum  <= '0;
                     state <= ST_SEND;
                  end
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            ST_SEND: begin
               if (!tx_busy) begin
                  tx_data     <= cur_byte;
                  new_tx_data <= 1'b1;
                  if (bidx != '0 && bidx != LAST_B) csum <= csum + cur_byte;
                  wait_first  <= 1'b1;
                  state       <= ST_WAIT_TX;
               end
            end
            ST_WAIT_TX: begin
               // The transmitter may not raise tx_busy until a cycle after the strobe.
               if (wait_first) begin
                  wait_first <= 1'b0;
               end else if (!tx_busy) begin
                  if (bidx == LAST_B) begin
                     frame_done <= 1'b1;
                     busy       <= 1'b0;
                     state      <= ST_IDLE;
                  end else begin
                     bidx  <= bidx + 1'b1;
                     state <= ST_SEND;
                  end
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_frame_tx.sv
// Directed bench for adc_frame_tx with two channels and a short timeout.
module tb_adc_frame_tx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [3:0] channel;
   logic       new_sample;
   logic [9:0] sample;
   logic [3:0] sample_channel;
   logic [7:0] tx_data;
   logic       new_tx_data;
   logic       tx_busy;
   logic       busy;
   logic       frame_done;
   logic       timeout_err;

   adc_frame_tx #(.NUM_CHANNELS(2), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .channel(channel),
      .new_sample(new_sample), .sample(sample), .sample_channel(sample_channel),
      .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
      .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] rx_q [$];
   int   tmo_cnt = 0, tmo_at = 0, fd_at = 0, rise_at = 0, ch1_start = 0;
   int   busy_len = 0, busy_left = 0;
   logic prev_strobe = 1'b0, prev_busy = 1'b0;
   logic [3:0] prev_ch = 4'd0;
   logic [7:0] exp_f [6];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_channel"}, channel, 0);
      chk({tag, "_tx_data"}, tx_data, 0);
      chk({tag, "_new_tx_data"}, new_tx_data, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_frame_done"}, frame_done, 0);
      chk({tag, "_timeout_err"}, timeout_err, 0);
   endtask

   task automatic feed(input logic [3:0] ch, input logic [9:0] v);
      new_sample = 1'b1; sample_channel = ch; sample = v;
      @(negedge clk);
      new_sample = 1'b0;
   endtask

   task automatic wait_busy(input string tag);
      int n = 0;
      while (!busy && n < 50) begin @(negedge clk); n++; end
      chk(tag, busy, 1);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (!frame_done && n < budget) begin @(negedge clk); n++; end
      chk(tag, frame_done, 1);
   endtask

   task automatic check_frame(input string tag, input logic [7:0] e [6]);
      logic [31:0] got;
      chk({tag, "_len"}, rx_q.size(), 6);
      for (int i = 0; i < 6; i++) begin
         got = (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hDEAD;
         chk($sformatf("%s_byte%0d", tag, i), got, {24'd0, e[i]});
      end
      rx_q.delete();
   endtask

   // Byte capture, handshake rules and a tx_busy model that holds busy for
   // busy_len cycles after each strobe.
   initial begin
      forever begin
         @(negedge clk);
         if (new_tx_data) begin
            rx_q.push_back(tx_data);
            chk("no_strobe_while_busy", tx_busy, 0);
            chk("no_back_to_back", prev_strobe, 0);
         end
         if (timeout_err) begin tmo_cnt++; tmo_at = cyc; end
         if (frame_done) fd_at = cyc;
         if (busy && !prev_busy) rise_at = cyc;
         if (busy && channel == 4'd1 && prev_ch != 4'd1) ch1_start = cyc;
         prev_strobe = new_tx_data;
         prev_busy   = busy;
         prev_ch     = channel;
         if (busy_left > 0) busy_left--;
         if (new_tx_data && busy_len > 0) busy_left = busy_len;
         tx_busy = (busy_left > 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b0; enable = 1'b0; new_sample = 1'b0; sample = '0;
      sample_channel = '0; tx_busy = 1'b0;
      repeat (3) @(negedge clk);
      chk_outputs_zero("reset");

      // Release with enable already high; nothing may move on the first edge.
      enable = 1'b1; rst_n = 1'b1;
      @(posedge clk); #1;
      chk("sync_release_edge1", busy, 0);
      @(negedge clk);
      wait_busy("t1_start");
      feed(4'd5, 10'h2AA);
      feed(4'd0, 10'h3FF);
      feed(4'd1, 10'h000);
      enable = 1'b0;
      wait_done("t1_done", 100);
      exp_f = '{8'hA5, 8'hFF, 8'h03, 8'h00, 8'h10, 8'h12};
      check_frame("t1", exp_f);
      chk("t1_no_timeout", tmo_cnt, 0);
      repeat (5) @(negedge clk);
      chk("t1_idle_hold", busy, 0);

      // Slow transmitter.
      busy_len = 10; enable = 1'b1;
      wait_busy("t2_start");
      feed(4'd0, 10'h155);
      feed(4'd1, 10'h2AA);
      enable = 1'b0;
      wait_done("t2_done", 300);
      exp_f = '{8'hA5, 8'h55, 8'h01, 8'hAA, 8'h12, 8'h12};
      check_frame("t2", exp_f);
      busy_len = 0;
      repeat (3) @(negedge clk);

      // Channel 1 never answers.
      enable = 1'b1;
      wait_busy("t3_start");
      feed(4'd0, 10'h100);
      enable = 1'b0;
      wait_done("t3_done", 100);
      chk("t3_timeout_count", tmo_cnt, 1);
      chk("t3_timeout_latency", tmo_at - ch1_start, 16);
      exp_f = '{8'hA5, 8'h00, 8'h01, 8'hFF, 8'h13, 8'h13};
      check_frame("t3", exp_f);
      repeat (3) @(negedge clk);

      // Channel 1 sample lands on the very cycle the counter expires.
      enable = 1'b1;
      wait_busy("t4_start");
      feed(4'd0, 10'h100);
      enable = 1'b0;
      repeat (15) @(negedge clk);
      feed(4'd1, 10'h0C3);
      wait_done("t4_done", 100);
      chk("t4_timeout_count", tmo_cnt, 1);
      exp_f = '{8'hA5, 8'h00, 8'h01, 8'hC3, 8'h10, 8'hD4};
      check_frame("t4", exp_f);
      repeat (3) @(negedge clk);

      // Enable held through frame_done: next scan with no gap, then all timeouts.
      enable = 1'b1;
      wait_busy("t5_start");
      feed(4'd0, 10'h001);
      feed(4'd1, 10'h3FE);
      wait_done("t5_done1", 100);
      exp_f = '{8'hA5, 8'h01, 8'h00, 8'hFE, 8'h13, 8'h12};
      check_frame("t5a", exp_f);
      @(negedge clk);
      @(negedge clk);
      chk("t5_restart_gap", rise_at - fd_at, 1);
      chk("t5_second_scan_busy", busy, 1);
      enable = 1'b0;
      wait_done("t5_done2", 200);
      chk("t5_timeout_count", tmo_cnt, 3);
      exp_f = '{8'hA5, 8'hFF, 8'h03, 8'hFF, 8'h13, 8'h14};
      check_frame("t5b", exp_f);
      repeat (5) @(negedge clk);
      chk("t5_idle_hold", busy, 0);

      // Reset while the third byte is in flight.
      busy_len = 10; enable = 1'b1;
      wait_busy("t6_start");
      feed(4'd0, 10'h155);
      feed(4'd1, 10'h2AA);
      enable = 1'b0;
      n = 0;
      while (rx_q.size() < 3 && n < 200) begin @(negedge clk); #1; n++; end
      chk("t6_third_byte", rx_q.size() >= 3, 1);
      rst_n = 1'b0;
      #1;
      chk_outputs_zero("t6_reset");
      rx_q.delete(); busy_len = 0; busy_left = 0; tx_busy = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; enable = 1'b1;
      wait_busy("t6_restart");
      feed(4'd0, 10'h0F0);
      feed(4'd1, 10'h00F);
      enable = 1'b0;
      wait_done("t6_done", 100);
      exp_f = '{8'hA5, 8'hF0, 8'h00, 8'h0F, 8'h10, 8'h0F};
      check_frame("t6", exp_f);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/adc_frame_tx.md
ADC_FRAME_TX -- requirements
Module: adc_frame_tx

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 8, number of ADC channels scanned per frame (legal 1..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, clk cycles to wait for a matching sample before substituting.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port enable  input  1  level; high = scan and transmit frames continuously.
REQ-006 SHALL have port channel  output  4  ADC channel select to the AVR interface.
REQ-007 SHALL have port new_sample  input  1  one-cycle strobe, sample/sample_channel valid.
REQ-008 SHALL have port sample  input  10  ADC result.
REQ-009 SHALL have port sample_channel  input  4  channel that produced sample.
REQ-010 SHALL have port tx_data  output  8  byte to serial transmitter.
REQ-011 SHALL have port new_tx_data  output  1  one-cycle strobe, tx_data valid.
REQ-012 SHALL have port tx_busy  input  1  serial transmitter busy.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after last frame byte is handed off.
REQ-015 SHALL have port timeout_err  output  1  one-cycle pulse when a channel times out.

Function
REQ-016 SHALL implement states IDLE, SCAN, SEND, WAIT_TX.
REQ-017 IDLE: when enable high, SHALL clear channel index k to 0, drive channel=0, enter SCAN next cycle.
REQ-018 SCAN: SHALL drive channel=k; on new_sample with sample_channel==k SHALL store sample in slot k; mismatching strobes SHALL be discarded.
REQ-019 SCAN: SHALL count cycles per channel; on reaching TIMEOUT_CYCLES without a match SHALL store 10'h3FF in slot k and pulse timeout_err.
REQ-020 After slot k stored: if k<NUM_CHANNELS-1 SHALL increment k and reset the timeout counter; else SHALL enter SEND with byte index 0.
REQ-021 Frame SHALL be, in order: header 0xA5; per channel k ascending: low byte sample[7:0], high byte {k[3:0], 2'b00, sample[9:8]}; checksum byte; length 2*NUM_CHANNELS+2.
REQ-022 Checksum SHALL be the 8-bit modulo-256 sum of all bytes after header, excluding itself.
REQ-023 SEND: when tx_busy low SHALL drive tx_data and pulse new_tx_data for exactly one cycle, then enter WAIT_TX.
REQ-024 WAIT_TX: SHALL ignore tx_busy for the first cycle, then wait for tx_busy low; then next byte -> SEND, or after checksum pulse frame_done and go to IDLE.
REQ-025 new_tx_data SHALL never be asserted while tx_busy high or on two consecutive cycles.
REQ-026 enable deassert mid-frame SHALL NOT abort; current frame completes, then IDLE holds.
REQ-027 enable high at frame_done SHALL start the next scan directly from IDLE next cycle, no extra gap.
REQ-028 new_sample coinciding with a timeout on the same cycle SHALL store the real sample; no timeout_err.
REQ-029 tx_data SHALL hold its value between strobes; channel SHALL hold last value outside SCAN.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, k=0, counters=0, slots=0, channel=0, tx_data=0, new_tx_data=0, busy=0, frame_done=0, timeout_err=0.
REQ-031 Reset mid-frame SHALL abort; after release no stale byte is sent, first byte of any new frame is 0xA5.
REQ-032 Reset release SHALL be synchronised so the first state change occurs no earlier than the second rising clk edge after release.

Structure
REQ-033 Header value 0xA5, state encodings, and the frame-length function SHALL live in shared package adc_frame_pkg.
REQ-034 Single module, no sub-module; sample slots SHALL be a NUM_CHANNELS x 10-bit register array.

Verification
REQ-035 NUM_CHANNELS=1, enable pulse, ch0 sample 0x155, tx_busy idle -> bytes A5, 55, 01, 56, then frame_done.
REQ-036 NUM_CHANNELS=2, samples ch0=0x3FF, ch1=0x000, preceded by stray ch5 strobe -> A5, FF, 03, 00, 10, 12; stray ignored.
REQ-037 TIMEOUT_CYCLES=16, no samples for ch1 -> timeout_err after 16 cycles in ch1, ch1 slot bytes FF, 13.
REQ-038 tx_busy held high 10 cycles after each strobe -> exactly one strobe per byte, none while busy high.
REQ-039 rst_n low during byte 3 of SEND -> all outputs zero immediately; after release and enable, first byte 0xA5.
REQ-040 enable held high -> back-to-back frames, second SCAN begins cycle after frame_done.
